router_in_port: RTL and testbench
=================================

ROUTER_IN_PORT -- requirements
Module: router_in_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in flits (power of two, >=2).
REQ-002 SHALL have parameter FLIT_W, default 34, flit width: bit33 = head, bit32 = tail, bits31:0 = payload; head flit payload bits2:0 = destination port.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream flit valid.
REQ-006 SHALL have port in_flit  input  FLIT_W  upstream flit.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a flit this cycle.
REQ-008 SHALL have port req  output  5  one-hot request to the output arbiters, bit k driving req_k of arbiter for output k.
REQ-009 SHALL have port hold  output  1  packet in progress, wired to the hold input of every output arbiter.
REQ-010 SHALL have port gnt  input  5  OR-combined grants for this input from the five arbiters (at most one bit set).
REQ-011 SHALL have port out_valid  output  1  out_flit is being transferred this cycle.
REQ-012 SHALL have port out_flit  output  FLIT_W  head-of-FIFO flit toward the crossbar.
REQ-013 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-014 SHALL push in_flit when in_valid & in_ready; in_ready SHALL be 1 iff count < DEPTH, independent of same-cycle pop.
REQ-015 SHALL pop when |(gnt & req); out_valid SHALL equal that pop condition; out_flit SHALL be the FIFO head combinationally.
REQ-016 SHALL not bypass: a flit pushed in cycle N is first visible on req in cycle N+1; push and pop in the same cycle SHALL leave count unchanged.
REQ-017 SHALL implement states IDLE and ACTIVE; IDLE -> ACTIVE on pop of a head flit without tail; ACTIVE -> IDLE on pop of a tail flit; head+tail (single-flit) pop SHALL stay IDLE.
REQ-018 In IDLE, req SHALL be the one-hot decode of head-flit dest when FIFO non-empty and head flit valid, else 0.
REQ-019 On head-flit pop, dest SHALL be latched into route; in ACTIVE, req SHALL equal route when FIFO non-empty, else 0.
REQ-020 hold SHALL be 1 iff state is ACTIVE, so the arbiter keeps this input granted across empty-FIFO bubbles until the tail is popped.
REQ-021 In IDLE, a FIFO-head flit without head bit, or with dest > 4, SHALL be discarded (popped without out_valid) in one cycle and set err.
REQ-022 A head flit arriving in ACTIVE SHALL be forwarded as a body flit and SHALL set err.
REQ-023 err SHALL remain 1 until reset.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-025 When rst_n = 0 at a rising edge: count, pointers, route = 0, state = IDLE, err = 0; req, hold, out_valid, in_ready (after reset: 1) derive from that state.
REQ-026 Reset mid-packet SHALL discard all stored flits; FIFO storage contents need not be cleared.

Structure
REQ-027 Package router_pkg SHALL hold NPORTS = 5, FLIT_W, head/tail bit positions, dest field position and width, and the state enum.
REQ-028 FIFO storage/pointers SHALL be sub-module flit_fifo (push, pop, full, empty, count); state machine, route decode, and error logic in router_in_port.

Verification
REQ-029 Single flit: push head+tail, dest 3, gnt 0 -> next cycle req = 5'b01000, hold 0; gnt = 5'b01000 -> out_valid 1, next cycle req 0, state IDLE.
REQ-030 3-flit packet to dest 1 with gnt held -> hold 1 after head pop, 0 the cycle after tail pop; req = 5'b00010 throughout.
REQ-031 Fill 4 flits, gnt 0 -> in_ready 0; simultaneous pop and in_valid -> no push, count 3, in_ready 1 next cycle.
REQ-032 Bubble: head popped, FIFO empty 3 cycles -> req 0, hold 1, out_valid 0; body then tail arrive -> forwarded, hold drops.
REQ-033 Body flit at head in IDLE -> popped without out_valid, err 1 sticky; rst_n low -> err 0, count 0, in_ready 1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router input port: flit layout, port count,
// port-state encoding and the destination decode helper.
package router_pkg;

  localparam int NPORTS   = 5;
  localparam int FLIT_W   = 34;
  localparam int HEAD_BIT = 33;
  localparam int TAIL_BIT = 32;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // One-hot request vector for a destination field; out-of-range codes give zero.
  function automatic logic [NPORTS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    logic [NPORTS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NPORTS; k++) begin
      oh[k] = (dest == DEST_W'(k));
    end
    return oh;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit storage for one router input: circular buffer with occupancy count.
// Pushes while full and pops while empty are ignored.
module flit_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 34,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage write; contents are left as-is across reset since count gates them.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Router input port: buffers incoming flits, requests the output named by the
// head flit, holds that output for the rest of the packet and flags malformed
// traffic with a sticky error.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | between packets; FIFO head must be a head flit with dest 0..4
//   ST_ACTIVE | packet in progress; requests the latched route until tail pops
module router_in_port #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = router_pkg::FLIT_W
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [FLIT_W-1:0]             in_flit,
  output logic                          in_ready,
  output logic [router_pkg::NPORTS-1:0] req,
  output logic                          hold,
  input  logic [router_pkg::NPORTS-1:0] gnt,
  output logic                          out_valid,
  output logic [FLIT_W-1:0]             out_flit,
  output logic                          err
);

  import router_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] head_flit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_pop;
  logic              is_head;
  logic              is_tail;
  logic [DEST_W-1:0] dest;
  logic              dest_ok;
  logic              discard;
  logic              grant_hit;
  logic [NPORTS-1:0] req_c;
  logic [NPORTS-1:0] route;
  state_e            state;
  logic              err_q;
  logic              unused_full;

  flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .CLK   (CLK),
    .rst_n (rst_n),
    .push  (in_valid & in_ready),
    .din   (in_flit),
    .pop   (fifo_pop),
    .dout  (head_flit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Readiness comes from occupancy alone, so a same-cycle pop never frees a slot early.
  assign in_ready    = (fifo_count < CW'(DEPTH));
  assign unused_full = fifo_full;

  assign is_head = head_flit[HEAD_BIT];
  assign is_tail = head_flit[TAIL_BIT];
  assign dest    = head_flit[DEST_LSB +: DEST_W];
  assign dest_ok = (dest < DEST_W'(NPORTS));

  // Request generation and discard of malformed packet starts.
  always_comb begin
    req_c   = '0;
    discard = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_IDLE) begin
        if (is_head && dest_ok) req_c = dest_onehot(dest);
        else                    discard = 1'b1;
      end else begin
        req_c = route;
      end
    end
  end

  assign req       = req_c;
  assign grant_hit = |(gnt & req_c);
  assign fifo_pop  = grant_hit | discard;
  assign out_valid = grant_hit;
  assign out_flit  = head_flit;
  assign hold      = (state == ST_ACTIVE);
  assign err       = err_q;

  // Packet state and route latch, advanced only by forwarded flits.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      route <= '0;
    end else if (grant_hit) begin
      case (state)
        ST_IDLE: begin
          if (!is_tail) begin
            state <= ST_ACTIVE;
            route <= req_c;
          end
        end
        ST_ACTIVE: begin
          if (is_tail) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: discarded flits, or a head flit forwarded inside a packet.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (discard || (grant_hit && (state == ST_ACTIVE) && is_head)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_in_port.sv
// Directed bench for router_in_port with a flit scoreboard on the output side.
module tb_router_in_port;

  localparam int DEPTH = 4;
  localparam int FW    = 34;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [FW-1:0] in_flit;
  logic          in_ready;
  logic [4:0]    req;
  logic          hold;
  logic [4:0]    gnt;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic          err;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [FW-1:0] exp_q[$];
  bit            in_rst = 1'b1;

  always #5 CLK = ~CLK;

  router_in_port #(.DEPTH(DEPTH), .FLIT_W(FW)) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .req       (req),
    .hold      (hold),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [31:0] p);
    return {h, t, p};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic send(input logic [FW-1:0] fl, input bit fwd);
    in_valid = 1'b1;
    in_flit  = fl;
    if (fwd) exp_q.push_back(fl);
  endtask

  task automatic do_reset;
    in_rst   = 1'b1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flit  = '0;
    gnt      = '0;
    tick;
    tick;
    rst_n = 1'b1;
    exp_q.delete();
    in_rst = 1'b0;
  endtask

  // Output scoreboard: every forwarded flit must match the next expected one in order.
  always @(negedge CLK) begin
    if (!in_rst && out_valid) begin
      logic [FW-1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("sb_flit", 64'(out_flit), 64'(e));
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flit  = '0;
    gnt      = '0;
    do_reset;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_req", req, 0);
    chk("rst_hold", hold, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_count", dut.fifo_count, 0);

    // single-flit packet to port 3
    send(mk(1, 1, 32'h0000_A003), 1);
    settle; chk("s1_no_bypass", req, 0);
    tick;
    in_valid = 1'b0;
    settle;
    chk("s1_req", req, 5'b01000);
    chk("s1_hold", hold, 0);
    chk("s1_ov_nogrant", out_valid, 0);
    gnt = 5'b01000;
    settle; chk("s1_out_valid", out_valid, 1);
    tick;
    gnt = '0;
    settle;
    chk("s1_req_after", req, 0);
    chk("s1_state_idle", dut.state, 0);
    chk("s1_count", dut.fifo_count, 0);

    // three-flit packet to port 1 with grant held
    gnt = 5'b00010;
    send(mk(1, 0, 32'h0000_0101), 1);
    settle; chk("p3_req_empty", req, 0);
    tick;
    send(mk(0, 0, 32'h1111_1111), 1);
    settle;
    chk("p3_head_req", req, 5'b00010);
    chk("p3_head_hold", hold, 0);
    chk("p3_head_ov", out_valid, 1);
    tick;
    send(mk(0, 1, 32'h2222_2222), 1);
    settle;
    chk("p3_body_hold", hold, 1);
    chk("p3_body_req", req, 5'b00010);
    tick;
    in_valid = 1'b0;
    settle;
    chk("p3_tail_hold", hold, 1);
    chk("p3_tail_req", req, 5'b00010);
    chk("p3_tail_ov", out_valid, 1);
    tick;
    gnt = '0;
    settle;
    chk("p3_after_hold", hold, 0);
    chk("p3_after_req", req, 0);

    // fill to DEPTH, then pop with in_valid asserted while full
    for (int i = 0; i < DEPTH; i++) begin
      send((i == 0) ? mk(1, 0, 32'h0000_0202) : mk(0, (i == DEPTH - 1), 32'h3000_0000 + i), 1);
      settle; chk("fill_ready", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
    settle;
    chk("full_ready", in_ready, 0);
    chk("full_count", dut.fifo_count, DEPTH);
    send(mk(0, 0, 32'hBAD0_BAD0), 0);
    gnt = 5'b00100;
    settle;
    chk("full_ready_pop", in_ready, 0);
    chk("full_pop_ov", out_valid, 1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("full_count3", dut.fifo_count, 3);
    chk("full_ready_next", in_ready, 1);
    for (int i = 0; i < 3; i++) tick;
    settle;
    chk("drain_count", dut.fifo_count, 0);
    chk("drain_hold", hold, 0);
    gnt = '0;

    // bubble inside a packet to port 4
    gnt = 5'b10000;
    send(mk(1, 0, 32'h0000_0004), 1);
    tick;
    in_valid = 1'b0;
    settle; chk("bub_head_ov", out_valid, 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("bub_req", req, 0);
      chk("bub_hold", hold, 1);
      chk("bub_ov", out_valid, 0);
      tick;
    end
    send(mk(0, 0, 32'h4444_0000), 1);
    settle; chk("bub_body_wait_ov", out_valid, 0);
    tick;
    send(mk(0, 1, 32'h4444_0001), 1);
    settle;
    chk("bub_body_ov", out_valid, 1);
    chk("bub_body_req", req, 5'b10000);
    tick;
    in_valid = 1'b0;
    settle;
    chk("bub_tail_ov", out_valid, 1);
    chk("bub_tail_hold", hold, 1);
    tick;
    settle; chk("bub_hold_drop", hold, 0);
    gnt = '0;

    // head flit arriving inside a packet is forwarded as body and flags err
    gnt = 5'b00001;
    send(mk(1, 0, 32'h0000_0000), 1);
    tick;
    send(mk(1, 0, 32'h0000_0003), 1);
    settle; chk("act_err_pre", err, 0);
    tick;
    send(mk(0, 1, 32'h5555_0005), 1);
    settle;
    chk("act_head_ov", out_valid, 1);
    chk("act_head_req", req, 5'b00001);
    tick;
    in_valid = 1'b0;
    settle; chk("act_head_err", err, 1);
    tick;
    settle; chk("act_hold_drop", hold, 0);
    gnt = '0;
    do_reset;
    chk("act_err_cleared", err, 0);

    // body flit at head while idle is dropped silently and sets err
    send(mk(0, 0, 32'h6666_0001), 0);
    tick;
    in_valid = 1'b0;
    settle;
    chk("disc_ov", out_valid, 0);
    chk("disc_req", req, 0);
    chk("disc_err_pre", err, 0);
    tick;
    settle;
    chk("disc_err", err, 1);
    chk("disc_count", dut.fifo_count, 0);

    // head flit with dest 6 is dropped even with every grant asserted
    gnt = 5'b11111;
    send(mk(1, 1, 32'h0000_0006), 0);
    tick;
    in_valid = 1'b0;
    settle;
    chk("bad_dest_ov", out_valid, 0);
    chk("bad_dest_req", req, 0);
    tick;
    settle;
    chk("bad_dest_count", dut.fifo_count, 0);
    chk("err_sticky", err, 1);
    gnt = '0;

    // reset in the middle of a packet drops buffered flits
    gnt = 5'b00001;
    send(mk(1, 0, 32'h0000_0000), 1);
    tick;
    send(mk(0, 0, 32'h7777_0001), 1);
    tick;
    gnt = '0;
    send(mk(0, 0, 32'h7777_0002), 1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("mid_hold", hold, 1);
    chk("mid_count", dut.fifo_count, 2);
    do_reset;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_count", dut.fifo_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_hold", hold, 0);
    chk("mid_rst_req", req, 0);

    tick;
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
